// File: rtl/logic_pkg.sv
// ----------------------------------------------------------------------------
// logic_pkg
//   Shared definitions for the buffered bitwise logic unit.
//   - OP_* : 3-bit operation encodings.
//   - logic_op(op, a, b) : single-bit evaluation of an operation. Callers apply
//     it per bit, so the unit is width-agnostic and has no carry paths.
// ----------------------------------------------------------------------------
package logic_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    function automatic logic logic_op(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;          // OP_PASS
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Show-ahead synchronous FIFO with asynchronous active-low reset.
//   Ports:
//     clk, rst_n        clock / async active-low reset
//     i_push, i_wdata   write request and data (ignored when full)
//     i_pop             read request (ignored when empty)
//     o_rdata           head entry while non-empty; last popped value when empty
//     o_full, o_empty   occupancy flags
//     o_level           occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    // Holds the most recently popped word so the output does not change to a
    // stale slot once the FIFO drains.
    logic [WIDTH-1:0] r_last;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? r_last : r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// ----------------------------------------------------------------------------
// logic_unit_pipe
//   Buffered bitwise logic unit: eight per-beat operations, optional
//   accumulate chaining across beats, results queued in a show-ahead FIFO.
//   Ports:
//     clk, rst_n            clock / async active-low reset
//     in_valid, in_ready    operand beat handshake
//     op, acc, acc_first    operation select, accumulate mode, chain start
//     x, y                  operands A and B
//     out_valid, out_ready  result handshake
//     out                   result at FIFO head
//     zero, ones            out == 0 / out == all ones
//     level                 FIFO occupancy
//
//   Handshake: a beat transfers on a rising edge where valid & ready are both
//   high; the source holds the beat stable until that edge. in_ready depends
//   only on registered occupancy, never on out_ready, so a drain frees a slot
//   one cycle later.
// ----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic                       acc,
    input  logic                       acc_first,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       zero,
    output logic                       ones,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_result;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    // Continuing a chain substitutes the running accumulator for x.
    assign w_a = (acc && !acc_first) ? r_acc : x;

    always_comb begin
        w_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_result[i] = logic_op(op, w_a[i], y[i]);
        end
    end

    assign in_ready  = ~w_full;
    assign w_push    = in_valid & in_ready;
    assign out_valid = ~w_empty;

    // Only accepted acc beats update the chain; non-acc beats may interleave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_push && acc) begin
            r_acc <= w_result;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_result),
        .i_pop   (out_ready),
        .o_rdata (out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign zero = (out == '0);
    assign ones = (out == '1);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Directed bench for logic_unit_pipe (WIDTH=16, DEPTH=2). Inputs are driven
//   and outputs sampled on the falling clock edge; the DUT acts on rising edges.
// ----------------------------------------------------------------------------
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH+1);

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic             acc = 1'b0;
    logic             acc_first = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ones;
    logic [LW-1:0]    level;

    logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc       (acc),
        .acc_first (acc_first),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .ones      (ones),
        .level     (level)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [2:0] b_op, input logic b_acc, input logic b_first,
                              input logic [WIDTH-1:0] b_x, input logic [WIDTH-1:0] b_y);
        in_valid  = 1'b1;
        op        = b_op;
        acc       = b_acc;
        acc_first = b_first;
        x         = b_x;
        y         = b_y;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        acc       = 1'b0;
        acc_first = 1'b0;
    endtask

    logic [WIDTH-1:0] ops_exp [8];
    int               sent;
    int               recv;
    int               cyc;
    logic             hold;
    logic [WIDTH-1:0] sx;

    initial begin
        ops_exp = '{16'h000F, 16'hF80F, 16'hF800, 16'hFFF0,
                    16'h07F0, 16'h07FF, 16'h0000, 16'h000F};

        // ---- 1. reset with stimulus toggling ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_beat(3'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)),
                       16'($urandom), 16'($urandom));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out", out, 0);
        check_val("rst_level", level, 0);
        check_val("rst_zero", zero, 1);
        check_val("rst_ones", ones, 0);
        drive_idle();
        out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);

        // ---- 2. all eight ops, one result per cycle ----
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_val($sformatf("op%0d_out", i - 1), out, ops_exp[i-1]);
                check_val($sformatf("op%0d_level", i - 1), level, 1);
                if (i == 7) check_val("andn_zero", zero, 1);
            end
            drive_beat(3'(i), 1'b0, 1'b0, 16'h000F, 16'hF80F);
        end
        @(negedge clk);
        check_val("op7_out", out, ops_exp[7]);
        drive_beat(OP_NAND, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_val("nand00_out", out, 16'hFFFF);
        check_val("nand00_ones", ones, 1);
        drive_idle();
        @(negedge clk);
        check_val("drained_valid", out_valid, 0);
        check_val("drained_hold_out", out, 16'hFFFF);
        check_val("drained_ones", ones, 1);

        // ---- 3. accumulate AND chain with an interleaved non-acc beat ----
        @(negedge clk);
        drive_beat(OP_AND, 1'b1, 1'b1, 16'hFFFF, 16'h0F0F);
        @(negedge clk);
        check_val("acc_b1", out, 16'h0F0F);
        drive_beat(OP_AND, 1'b1, 1'b0, 16'hAAAA, 16'h00FF);
        @(negedge clk);
        check_val("acc_b2", out, 16'h000F);
        drive_beat(OP_OR, 1'b0, 1'b0, 16'h1234, 16'h0000);
        @(negedge clk);
        check_val("acc_interleave", out, 16'h1234);
        drive_beat(OP_AND, 1'b1, 1'b0, 16'h5555, 16'h0003);
        @(negedge clk);
        check_val("acc_b3", out, 16'h0003);
        drive_idle();
        @(negedge clk);

        // ---- 4. backpressure ----
        out_ready = 1'b0;
        drive_beat(OP_PASS, 1'b0, 1'b0, 16'h00A1, 16'h0);
        @(negedge clk);
        drive_beat(OP_PASS, 1'b0, 1'b0, 16'h00B2, 16'h0);
        @(negedge clk);
        drive_beat(OP_PASS, 1'b0, 1'b0, 16'h00C3, 16'h0);
        @(negedge clk);
        check_val("bp_level_full", level, 2);
        check_val("bp_in_ready_low", in_ready, 0);
        check_val("bp_head_a", out, 16'h00A1);
        @(negedge clk);
        check_val("bp_third_held", level, 2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_after_drain_level", level, 1);
        check_val("bp_in_ready_next", in_ready, 1);
        check_val("bp_head_b", out, 16'h00B2);
        @(negedge clk);
        drive_idle();
        check_val("bp_third_accepted", level, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_head_c", out, 16'h00C3);
        @(negedge clk);
        check_val("bp_empty", out_valid, 0);

        // ---- 5. simultaneous accept/drain at level 1, then streaming ----
        out_ready = 1'b0;
        drive_beat(OP_PASS, 1'b0, 1'b0, 16'h0D0D, 16'h0);
        @(negedge clk);
        check_val("sim_level1", level, 1);
        out_ready = 1'b1;
        drive_beat(OP_PASS, 1'b0, 1'b0, 16'h0E0E, 16'h0);
        @(negedge clk);
        drive_idle();
        check_val("sim_level_same", level, 1);
        check_val("sim_head_e", out, 16'h0E0E);
        @(negedge clk);

        sent = 0;
        recv = 0;
        cyc  = 0;
        hold = 1'b0;
        while ((sent < 20 || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                if (sent < 20) begin
                    sx = 16'hA000 + 16'(sent);
                    drive_beat(OP_XOR, 1'b0, 1'b0, sx, 16'h0F0F);
                end else begin
                    drive_idle();
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("stream_extra", 1, 0);
                end else begin
                    check_val($sformatf("stream_data%0d", recv), out, exp_q.pop_front());
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(x ^ y);
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
        end
        @(negedge clk);
        drive_idle();
        check_val("stream_count", recv, 20);
        check_val("stream_level0", level, 0);

        // ---- 6. reset mid-operation ----
        out_ready = 1'b0;
        drive_beat(OP_XOR, 1'b1, 1'b1, 16'h5555, 16'h0000);
        @(negedge clk);
        drive_beat(OP_XOR, 1'b1, 1'b0, 16'h0000, 16'h00FF);
        @(negedge clk);
        drive_idle();
        check_val("mid_level_full", level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_level", level, 0);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_out", out, 0);
        check_val("mid_rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive_beat(OP_XOR, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
        @(negedge clk);
        drive_idle();
        check_val("post_rst_acc_out", out, 16'h1234);
        check_val("post_rst_valid", out_valid, 1);
        @(negedge clk);

        // ---- report ----
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
